// File: rtl/ahb_if_pkg.sv
// Shared encodings for the AHB-Lite slave front end of the AHB-to-APB bridge.
// The FSM state list depends on AHB_IF_ERR_RESP_EN: the two ERROR-response
// states only exist when that macro is defined.
package ahb_if_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_RDRAIN,
    ST_RREQ,
    ST_RRSP,
    ST_RDONE
`ifdef AHB_IF_ERR_RESP_EN
    ,
    ST_ERR1,
    ST_ERR2
`endif
  } state_e;

endpackage

// File: rtl/ahb_wbuf_fifo.sv
// Posted-write buffer: synchronous FIFO holding {addr, wdata, sel} entries.
// DEPTH is a power of two so the pointers wrap naturally.
module ahb_wbuf_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];
  assign level_o = level_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PW'(1);
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/ahb_apb_if_buf.sv
// AHB-Lite slave front end with posted-write buffer feeding the APB
// controller through the req_*/rsp_* channel. Unmapped accesses get a
// two-cycle ERROR when AHB_IF_ERR_RESP_EN is defined, otherwise OKAY
// (writes dropped, reads return zero).
//
// state  | meaning
// IDLE   | no data phase owed, ready for an address phase
// WDATA  | write data phase: push hwdata into buffer, stall if full
// RDRAIN | read pending, waiting for posted writes to drain
// RREQ   | read request presented downstream
// RRSP   | waiting for downstream read data
// RDONE  | read data phase completes, hrdata valid
// ERR1   | first ERROR cycle (hreadyout low)
// ERR2   | second ERROR cycle (hreadyout high)
module ahb_apb_if_buf
  import ahb_if_pkg::*;
#(
  parameter int             AW        = 32,
  parameter int             DW        = 32,
  parameter int             NUM_SLV   = 3,
  parameter int             REGION_AW = 26,
  parameter logic [AW-1:0]  BASE_ADDR = 32'h8000_0000,
  parameter int             DEPTH     = 4,
  localparam int            LW        = $clog2(DEPTH + 1)
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hwrite,
  input  logic               hreadyin,
  input  logic [1:0]         htrans,
  input  logic [AW-1:0]      haddr,
  input  logic [DW-1:0]      hwdata,
  output logic               hreadyout,
  output logic               hresp,
  output logic [DW-1:0]      hrdata,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_write,
  output logic [AW-1:0]      req_addr,
  output logic [DW-1:0]      req_wdata,
  output logic [NUM_SLV-1:0] req_sel,
  input  logic               rsp_valid,
  input  logic [DW-1:0]      rsp_rdata,
  output logic [LW-1:0]      wbuf_level
);

  localparam int FW = AW + DW + NUM_SLV;

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [NUM_SLV-1:0] sel_q, sel_d;
  logic [DW-1:0]      hrdata_q, hrdata_d;
  logic [AW-1:0]      rgn_idx;
  logic               mapped;
  logic [NUM_SLV-1:0] dec_sel;
  logic               can_accept, accept, push, pop, full, empty;
  logic [FW-1:0]      head;

  // Region decode of the current address phase.
  always_comb begin
    rgn_idx = (haddr - BASE_ADDR) >> REGION_AW;
    mapped  = (haddr >= BASE_ADDR) && (rgn_idx < AW'(NUM_SLV));
    dec_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) dec_sel[i] = mapped && (rgn_idx == AW'(i));
  end

  // Next-state, AHB response and address-phase capture.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    hrdata_d   = hrdata_q;
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    push       = 1'b0;
    can_accept = 1'b0;
    case (state_q)
      ST_IDLE, ST_RDONE: begin
        can_accept = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_WDATA: begin
        // A pop in the same cycle does not free a slot early.
        if (full) hreadyout = 1'b0;
        else begin
          push       = 1'b1;
          can_accept = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_RDRAIN: begin
        hreadyout = 1'b0;
        if (empty) state_d = ST_RREQ;
      end
      ST_RREQ: begin
        hreadyout = 1'b0;
        if (req_ready) state_d = ST_RRSP;
      end
      ST_RRSP: begin
        hreadyout = 1'b0;
        if (rsp_valid) begin
          hrdata_d = rsp_rdata;
          state_d  = ST_RDONE;
        end
      end
`ifdef AHB_IF_ERR_RESP_EN
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = HRESP_ERROR;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    accept = can_accept && hreadyin &&
             ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    if (accept) begin
      addr_d = haddr;
      sel_d  = dec_sel;
      if (mapped) state_d = hwrite ? ST_WDATA : ST_RDRAIN;
      else begin
        if (!hwrite) hrdata_d = '0;
`ifdef AHB_IF_ERR_RESP_EN
        state_d = ST_ERR1;
`else
        state_d = ST_IDLE;
`endif
      end
    end
  end

  // Downstream request mux: the pending read owns the channel in RREQ,
  // otherwise the buffer head is offered.
  always_comb begin
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_sel   = '0;
    if (state_q == ST_RREQ) begin
      req_valid = 1'b1;
      req_addr  = addr_q;
      req_sel   = sel_q;
    end else if (!empty) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      {req_addr, req_wdata, req_sel} = head;
    end
  end

  assign pop    = req_valid && req_write && req_ready;
  assign hrdata = hrdata_q;

  // State and captured address-phase registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      sel_q    <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      hrdata_q <= hrdata_d;
    end
  end

  ahb_wbuf_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_wbuf (
    .clk_i   (hclk),
    .rst_ni  (hresetn),
    .push_i  (push),
    .data_i  ({addr_q, hwdata, sel_q}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (wbuf_level)
  );

endmodule

// File: tb/tb_ahb_apb_if_buf.sv
// Bench for ahb_apb_if_buf: directed AHB transfers with a scoreboard of
// expected downstream writes and expected read data.
module tb_ahb_apb_if_buf;
  import ahb_if_pkg::*;

  logic        hclk, hresetn, hwrite, hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hreadyout, hresp;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_sel;
  logic        rsp_valid;
  logic [2:0]  wbuf_level;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  s;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_pops  = 0;

  ahb_apb_if_buf dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_sel(req_sel), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .wbuf_level(wbuf_level)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Scoreboard for posted writes leaving the buffer.
  always @(negedge hclk) begin
    if (hresetn && req_valid && req_ready && req_write) begin
      wr_t e;
      wr_pops++;
      chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0) begin
        e = exp_wr.pop_front();
        chk("wr_addr", req_addr, e.a);
        chk("wr_data", req_wdata, e.d);
        chk("wr_sel", 32'(req_sel), 32'(e.s));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hready"}, 32'(hreadyout), 32'd1);
    chk({tag, "_hresp"}, 32'(hresp), 32'd0);
    chk({tag, "_hrdata"}, hrdata, 32'd0);
    chk({tag, "_req_valid"}, 32'(req_valid), 32'd0);
    chk({tag, "_req_write"}, 32'(req_write), 32'd0);
    chk({tag, "_req_addr"}, req_addr, 32'd0);
    chk({tag, "_req_wdata"}, req_wdata, 32'd0);
    chk({tag, "_req_sel"}, 32'(req_sel), 32'd0);
    chk({tag, "_level"}, 32'(wbuf_level), 32'd0);
  endtask

  // Drive a read address phase now (called right after a tick) and
  // act as the downstream responder until the data phase completes.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] exp_sel, input int exp_pops);
    int p0;
    bit found;
    htrans = HTRANS_NONSEQ; haddr = addr; hwrite = 1'b0;
    exp_rd.push_back(data);
    tick();
    htrans = HTRANS_IDLE; req_ready = 1'b1;
    p0 = wr_pops; found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge hclk);
      if (req_valid && !req_write) found = 1'b1;
      else begin
        chk("rd_stall_hready", 32'(hreadyout), 32'd0);
        tick();
      end
    end
    chk("rd_req_seen", 32'(found), 32'd1);
    chk("rd_after_pops", 32'(wr_pops - p0), 32'(exp_pops));
    chk("rd_req_addr", req_addr, addr);
    chk("rd_req_sel", 32'(req_sel), 32'(exp_sel));
    chk("rd_req_hready", 32'(hreadyout), 32'd0);
    tick(); req_ready = 1'b0;
    @(negedge hclk); chk("rrsp_hready", 32'(hreadyout), 32'd0);
    tick(); rsp_valid = 1'b1; rsp_rdata = data;
    @(negedge hclk); chk("rsp_cycle_hready", 32'(hreadyout), 32'd0);
    tick(); rsp_valid = 1'b0; rsp_rdata = 32'd0;
    @(negedge hclk);
    chk("rdone_hready", 32'(hreadyout), 32'd1);
    chk("rd_queue", 32'(exp_rd.size()), 32'd1);
    if (exp_rd.size() > 0) chk("rd_data", hrdata, exp_rd.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    hresetn = 1'b0; hwrite = 1'b0; hreadyin = 1'b1; htrans = HTRANS_IDLE;
    haddr = 32'd0; hwdata = 32'd0; req_ready = 1'b0; rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk_reset_vals("reset");
    tick(); hresetn = 1'b1;

    // Single posted write, zero wait states.
    tick(); req_ready = 1'b1;
    htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h8400_0010;
    exp_wr.push_back('{a: 32'h8400_0010, d: 32'hDEAD_BEEF, s: 3'b010});
    tick(); htrans = HTRANS_IDLE; hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    chk("w1_hready", 32'(hreadyout), 32'd1);
    chk("w1_level_dphase", 32'(wbuf_level), 32'd0);
    tick();
    @(negedge hclk);
    chk("w1_req_valid", 32'(req_valid), 32'd1);
    chk("w1_req_write", 32'(req_write), 32'd1);
    chk("w1_req_sel", 32'(req_sel), 32'b010);
    chk("w1_req_wdata", req_wdata, 32'hDEAD_BEEF);
    tick();
    @(negedge hclk);
    chk("w1_drained", 32'(wbuf_level), 32'd0);

    // Five back-to-back writes against a stalled downstream.
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h8000_0100 + 32'(i * 4);
      if (i > 0) hwdata = 32'hA000_0000 + 32'(i - 1);
      exp_wr.push_back('{a: 32'h8000_0100 + 32'(i * 4), d: 32'hA000_0000 + 32'(i), s: 3'b001});
      if (i > 0) begin
        @(negedge hclk);
        chk("w5_pipe_hready", 32'(hreadyout), 32'd1);
      end
    end
    tick(); htrans = HTRANS_IDLE; hwdata = 32'hA000_0004;
    @(negedge hclk);
    chk("w5_full_hready", 32'(hreadyout), 32'd0);
    chk("w5_peak_level", 32'(wbuf_level), 32'd4);
    tick();
    @(negedge hclk);
    chk("w5_full_hold", 32'(hreadyout), 32'd0);
    tick(); req_ready = 1'b1;
    @(negedge hclk);
    chk("w5_pop_blocks_push", 32'(hreadyout), 32'd0);
    tick();
    @(negedge hclk);
    chk("w5_resume_hready", 32'(hreadyout), 32'd1);
    chk("w5_resume_level", 32'(wbuf_level), 32'd3);
    for (int n = 0; n < 30 && wbuf_level != 3'd0; n++) tick();
    @(negedge hclk);
    chk("w5_drain_level", 32'(wbuf_level), 32'd0);
    chk("w5_sb_empty", 32'(exp_wr.size()), 32'd0);

    // Two queued writes, then a read that must wait for both to drain.
    tick(); req_ready = 1'b0;
    htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h8000_0200;
    exp_wr.push_back('{a: 32'h8000_0200, d: 32'h5A5A_0001, s: 3'b001});
    tick(); hwdata = 32'h5A5A_0001; haddr = 32'h8000_0204;
    exp_wr.push_back('{a: 32'h8000_0204, d: 32'h5A5A_0002, s: 3'b001});
    tick(); hwdata = 32'h5A5A_0002;
    do_read(32'h8800_0000, 32'h1234_5678, 3'b100, 2);
    tick(); rsp_valid = 1'b1; rsp_rdata = 32'hFFFF_FFFF;
    tick(); rsp_valid = 1'b0; rsp_rdata = 32'd0;
    @(negedge hclk);
    chk("stray_rsp_ignored", hrdata, 32'h1234_5678);
    chk("stray_rsp_hready", 32'(hreadyout), 32'd1);

    // Reset with two writes buffered.
    tick(); req_ready = 1'b0;
    htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h8400_0000;
    exp_wr.push_back('{a: 32'h8400_0000, d: 32'h0000_0001, s: 3'b010});
    tick(); hwdata = 32'h0000_0001; haddr = 32'h8400_0004;
    exp_wr.push_back('{a: 32'h8400_0004, d: 32'h0000_0002, s: 3'b010});
    tick(); hwdata = 32'h0000_0002; htrans = HTRANS_IDLE;
    tick();
    @(negedge hclk);
    chk("rstq_level", 32'(wbuf_level), 32'd2);
    tick(); hresetn = 1'b0; exp_wr.delete();
    @(negedge hclk);
    chk_reset_vals("rstq");
    tick(); hresetn = 1'b1;

    // Reset while waiting for read data; late rsp_valid must be ignored.
    tick(); htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h8000_0000;
    tick(); htrans = HTRANS_IDLE; req_ready = 1'b1;
    tick();
    @(negedge hclk);
    chk("rstr_rreq", 32'(req_valid && !req_write), 32'd1);
    tick(); req_ready = 1'b0;
    @(negedge hclk);
    chk("rstr_rrsp_hready", 32'(hreadyout), 32'd0);
    tick(); hresetn = 1'b0;
    @(negedge hclk);
    chk_reset_vals("rstr");
    tick(); hresetn = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'hBAD0_BAD0;
    tick(); rsp_valid = 1'b0; rsp_rdata = 32'd0;
    @(negedge hclk);
    chk("rstr_late_rsp_hrdata", hrdata, 32'd0);
    chk("rstr_late_rsp_hready", 32'(hreadyout), 32'd1);

    // IDLE and BUSY transfers to a mapped address are ignored.
    tick(); htrans = HTRANS_IDLE; hwrite = 1'b1; haddr = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      tick(); htrans = (i == 0) ? HTRANS_BUSY : HTRANS_IDLE;
      hwdata = 32'h7777_0000 + 32'(i);
      @(negedge hclk);
      chk("idle_hready", 32'(hreadyout), 32'd1);
      chk("idle_req_valid", 32'(req_valid), 32'd0);
      chk("idle_level", 32'(wbuf_level), 32'd0);
    end

    // Plain mapped read from an empty buffer.
    tick();
    do_read(32'h8000_0040, 32'hCAFE_F00D, 3'b001, 0);

    // Unmapped accesses.
`ifdef AHB_IF_ERR_RESP_EN
    tick(); htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h9000_0000;
    tick(); htrans = HTRANS_IDLE;
    @(negedge hclk);
    chk("err1_hresp", 32'(hresp), 32'd1);
    chk("err1_hready", 32'(hreadyout), 32'd0);
    tick();
    @(negedge hclk);
    chk("err2_hresp", 32'(hresp), 32'd1);
    chk("err2_hready", 32'(hreadyout), 32'd1);
    tick();
    @(negedge hclk);
    chk("err_done_hresp", 32'(hresp), 32'd0);
    chk("err_done_hready", 32'(hreadyout), 32'd1);
`else
    tick(); htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h9000_0000;
    tick(); hwdata = 32'h1111_1111; hwrite = 1'b0; haddr = 32'h9000_0004;
    @(negedge hclk);
    chk("unm_wr_hready", 32'(hreadyout), 32'd1);
    chk("unm_wr_hresp", 32'(hresp), 32'd0);
    tick(); htrans = HTRANS_IDLE;
    @(negedge hclk);
    chk("unm_rd_hready", 32'(hreadyout), 32'd1);
    chk("unm_rd_hresp", 32'(hresp), 32'd0);
    chk("unm_rd_data", hrdata, 32'd0);
    chk("unm_no_push", 32'(wbuf_level), 32'd0);
    chk("unm_no_req", 32'(req_valid), 32'd0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
